ast_dmx_skid: RTL and testbench

- Parametrised Avalon-ST 1-to-TX_DIR packet demultiplexer; successor to the fixed single-beat-steering demux.
- Routing direction is sampled on each accepted start-of-packet beat and held until end-of-packet.
- Each output has a 2-entry skid buffer, so there is no combinational path from any downstream ready to ast_ready_o.
- Out-of-range directions are handled by mode: drop or default-route. Protocol errors are flagged.
- Sits between the packet classifier and the per-port TX pipelines.

---
 rtl/ast_dmx_skid_pkg.sv | 8 +
 rtl/ast_skid_buf.sv | 31 +++
 rtl/ast_dmx_skid.sv | 105 ++++++++++
 tb/tb_ast_dmx_skid.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_dmx_skid_pkg.sv
// ast_dmx_skid_pkg: shared types and helpers for the skid-buffered packet demultiplexer
package ast_dmx_skid_pkg;
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
  localparam int SKID_DEPTH = 2;
  function automatic logic dir_valid(input int unsigned dir, input int unsigned n);
    return dir < n;
  endfunction
endpackage

// File: rtl/ast_skid_buf.sv
// ast_skid_buf: two-entry register FIFO that keeps downstream ready off the upstream ready path
module ast_skid_buf import ast_dmx_skid_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [1:0]   cnt;
  logic [W-1:0] head, tail;
  logic         wr, rd;
  always_comb begin
    full  = cnt == 2'(SKID_DEPTH);
    empty = cnt == 2'd0;
    wr    = push & ~full;
    rd    = pop & ~empty;
    dout  = head;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    if (rd) head <= full ? tail : din;
    else if (wr && empty) head <= din;
    if (wr && !rd && cnt == 2'd1) tail <= din;
  end
endmodule

// File: rtl/ast_dmx_skid.sv
// ast_dmx_skid: Avalon-ST 1-to-TX_DIR packet demux, direction latched per packet, per-port skid buffers
module ast_dmx_skid import ast_dmx_skid_pkg::*; #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = $clog2(TX_DIR),
  parameter bit DROP_INVALID  = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic [DIR_SEL_WIDTH-1:0]              dir_i,
  input  logic [DATA_WIDTH-1:0]                 ast_data_i,
  input  logic                                  ast_startofpacket_i,
  input  logic                                  ast_endofpacket_i,
  input  logic                                  ast_valid_i,
  input  logic [EMPTY_WIDTH-1:0]                ast_empty_i,
  input  logic [CHANNEL_WIDTH-1:0]              ast_channel_i,
  output logic                                  ast_ready_o,
  output logic [TX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_o,
  output logic [TX_DIR-1:0]                     ast_startofpacket_o,
  output logic [TX_DIR-1:0]                     ast_endofpacket_o,
  output logic [TX_DIR-1:0]                     ast_valid_o,
  output logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_o,
  output logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]  ast_channel_o,
  input  logic [TX_DIR-1:0]                     ast_ready_i,
  output logic                                  drop_o,
  output logic                                  err_o
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;
  } beat_t;
  localparam int BW = $bits(beat_t);
  state_t                   state, state_nxt;
  logic [DIR_SEL_WIDTH-1:0] dir_q, dir_nxt, routed;
  logic [TX_DIR-1:0]        full, empty, push, pop;
  logic                     dir_bad, sop_drop, acc, drop_nxt, err_nxt;
  beat_t                    beat_in;
  beat_t [TX_DIR-1:0]       head;
  // An SOP always targets routed(dir_i), even mid-packet, so ready follows the port it will land in
  always_comb begin
    dir_bad     = !dir_valid(32'(dir_i), TX_DIR);
    sop_drop    = dir_bad & DROP_INVALID;
    routed      = dir_bad ? '0 : dir_i;
    ast_ready_o = (state == FWD && !ast_startofpacket_i) ? ~full[dir_q] :
                  (state == DROP && !ast_startofpacket_i) ? 1'b1 : sop_drop | ~full[routed];
    acc         = ast_valid_i & ast_ready_o;
    beat_in     = {ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i};
  end
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    push      = '0;
    drop_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (acc && ast_startofpacket_i) begin
      err_nxt      = state != IDLE;
      dir_nxt      = routed;
      push[routed] = ~sop_drop;
      drop_nxt     = sop_drop & ast_endofpacket_i;
      state_nxt    = ast_endofpacket_i ? IDLE : sop_drop ? DROP : FWD;
    end else if (acc) begin
      push[dir_q] = state == FWD;
      drop_nxt    = state == DROP && ast_endofpacket_i;
      err_nxt     = state == IDLE;
      state_nxt   = ast_endofpacket_i ? IDLE : state;
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      dir_q  <= '0;
      drop_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      dir_q  <= dir_nxt;
      drop_o <= drop_nxt;
      err_o  <= err_nxt;
    end
  end
  for (genvar i = 0; i < TX_DIR; i++) begin : g_port
    ast_skid_buf #(.W(BW)) u_buf (
      .clk   (clk_i),
      .rst   (srst_i),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (beat_in),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
    assign pop[i]                 = ast_valid_o[i] & ast_ready_i[i];
    assign ast_valid_o[i]         = ~empty[i];
    assign ast_data_o[i]          = head[i].data;
    assign ast_startofpacket_o[i] = head[i].sop;
    assign ast_endofpacket_o[i]   = head[i].eop;
    assign ast_empty_o[i]         = head[i].empty;
    assign ast_channel_o[i]       = head[i].channel;
  end
endmodule

// File: tb/tb_ast_dmx_skid.sv
// tb_ast_dmx_skid: vector table, directed corner cases and random traffic against a queue-based model
module tb_ast_dmx_skid;
  localparam int DW = 32, CW = 4, EW = 2, N = 5, DSW = 3;
  logic clk = 1'b0, srst = 1'b1, sel = 1'b0, vin = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [DSW-1:0] dir = '0;
  logic [DW-1:0] data = '0;
  logic [EW-1:0] emp = '0;
  logic [CW-1:0] chan = '0;
  logic [N-1:0] rdy = '1;
  logic rdy_a, rdy_b, drop_a, drop_b, err_a, err_b;
  logic [N-1:0][DW-1:0] dat_a, dat_b;
  logic [N-1:0] so_a, so_b, eo_a, eo_b, vo_a, vo_b;
  logic [N-1:0][EW-1:0] em_a, em_b;
  logic [N-1:0][CW-1:0] ch_a, ch_b;
  logic rdy_s, drop_s, err_s;
  logic [N-1:0][DW-1:0] dat_s;
  logic [N-1:0] so_s, eo_s, vo_s;
  logic [N-1:0][EW-1:0] em_s;
  logic [N-1:0][CW-1:0] ch_s;

  always #5 clk = ~clk;

  ast_dmx_skid #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .TX_DIR(N),
                 .DIR_SEL_WIDTH(DSW), .DROP_INVALID(1'b1)) dut_a (
    .clk_i(clk), .srst_i(srst), .dir_i(dir), .ast_data_i(data), .ast_startofpacket_i(sop),
    .ast_endofpacket_i(eop), .ast_valid_i(vin & ~sel), .ast_empty_i(emp), .ast_channel_i(chan),
    .ast_ready_o(rdy_a), .ast_data_o(dat_a), .ast_startofpacket_o(so_a), .ast_endofpacket_o(eo_a),
    .ast_valid_o(vo_a), .ast_empty_o(em_a), .ast_channel_o(ch_a), .ast_ready_i(rdy),
    .drop_o(drop_a), .err_o(err_a));

  ast_dmx_skid #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .TX_DIR(N),
                 .DIR_SEL_WIDTH(DSW), .DROP_INVALID(1'b0)) dut_b (
    .clk_i(clk), .srst_i(srst), .dir_i(dir), .ast_data_i(data), .ast_startofpacket_i(sop),
    .ast_endofpacket_i(eop), .ast_valid_i(vin & sel), .ast_empty_i(emp), .ast_channel_i(chan),
    .ast_ready_o(rdy_b), .ast_data_o(dat_b), .ast_startofpacket_o(so_b), .ast_endofpacket_o(eo_b),
    .ast_valid_o(vo_b), .ast_empty_o(em_b), .ast_channel_o(ch_b), .ast_ready_i(rdy),
    .drop_o(drop_b), .err_o(err_b));

  assign rdy_s  = sel ? rdy_b : rdy_a;
  assign drop_s = sel ? drop_b : drop_a;
  assign err_s  = sel ? err_b : err_a;
  assign dat_s  = sel ? dat_b : dat_a;
  assign so_s   = sel ? so_b : so_a;
  assign eo_s   = sel ? eo_b : eo_a;
  assign vo_s   = sel ? vo_b : vo_a;
  assign em_s   = sel ? em_b : em_a;
  assign ch_s   = sel ? ch_b : ch_a;

  // Reference: one queue of expected beats per port; its length is that port's occupancy
  typedef struct packed {logic [DW-1:0] d; logic s, e; logic [EW-1:0] em; logic [CW-1:0] ch;} beat_t;
  beat_t q[N][$];
  int mst, mdir, n_chk, n_fail;
  int rx[N];
  bit x_drop, x_err, x_ready;

  typedef struct {bit sel, v, s, e; int dir; logic [EW-1:0] em; bit xr; logic [N-1:0] vm; bit xe, xd;} vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mst = 0;
    mdir = 0;
    x_drop = 0;
    x_err = 0;
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      rx[p] = 0;
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    vin = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    model_clear();
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input int d);
    vin = v;
    sop = s;
    eop = e;
    dir = DSW'(d);
    data = $urandom;
    emp = EW'($urandom);
    chan = CW'($urandom);
  endtask

  task automatic step_check();
    bit bad;
    int rt;
    beat_t h;
    @(negedge clk);
    bad = int'(dir) >= N;
    rt = bad ? 0 : int'(dir);
    if (mst != 0 && !sop) x_ready = (mst == 2) || q[mdir].size() < 2;
    else x_ready = (bad && !sel) || q[rt].size() < 2;
    chk("ready_o", rdy_s, x_ready);
    chk("err_o", err_s, x_err);
    chk("drop_o", drop_s, x_drop);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("valid_o[%0d]", p), vo_s[p], q[p].size() != 0);
      if (q[p].size() != 0 && vo_s[p]) begin
        h = q[p][0];
        chk($sformatf("data_o[%0d]", p), dat_s[p], h.d);
        chk($sformatf("sop_o[%0d]", p), so_s[p], h.s);
        chk($sformatf("eop_o[%0d]", p), eo_s[p], h.e);
        chk($sformatf("channel_o[%0d]", p), ch_s[p], h.ch);
        if (h.e) chk($sformatf("empty_o[%0d]", p), em_s[p], h.em);
      end
    end
  endtask

  task automatic step_adv();
    bit bad;
    int rt;
    beat_t b;
    bad = int'(dir) >= N;
    rt = bad ? 0 : int'(dir);
    x_drop = 0;
    x_err = 0;
    for (int p = 0; p < N; p++)
      if (q[p].size() != 0 && rdy[p]) begin
        void'(q[p].pop_front());
        rx[p]++;
      end
    b = {data, sop, eop, emp, chan};
    if (srst) model_clear();
    else if (vin && x_ready) begin
      if (sop) begin
        x_err = mst != 0;
        if (bad && !sel) begin
          x_drop = eop;
          mst = eop ? 0 : 2;
        end else begin
          q[rt].push_back(b);
          mdir = rt;
          mst = eop ? 0 : 1;
        end
      end else if (mst == 1) begin
        q[mdir].push_back(b);
        if (eop) mst = 0;
      end else if (mst == 2) begin
        x_drop = eop;
        if (eop) mst = 0;
      end else x_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit sl, input bit v, input bit s, input bit e, input int d,
                     input int em, input bit xr, input logic [N-1:0] vm, input bit xe, input bit xd);
    vec_t t;
    t = '{sl, v, s, e, d, EW'(em), xr, vm, xe, xd};
    tbl.push_back(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    bit r0, acc;
    // sel, v, sop, eop, dir, empty | ready_o, valid mask, err, drop
    add(0, 1, 1, 0, 2, 0, 1, 5'b00000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 5'b00100, 0, 0);
    add(0, 1, 0, 1, 0, 3, 1, 5'b00100, 0, 0);
    add(0, 1, 1, 1, 0, 1, 1, 5'b00100, 0, 0);
    add(0, 1, 1, 1, 1, 2, 1, 5'b00001, 0, 0);
    add(0, 1, 1, 1, 2, 0, 1, 5'b00010, 0, 0);
    add(0, 1, 1, 1, 3, 3, 1, 5'b00100, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b01000, 0, 0);
    add(0, 1, 1, 0, 6, 0, 1, 5'b00000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 5'b00000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00000, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 5'b00000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 5'b00001, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 5'b00001, 0, 0);
    add(0, 1, 0, 1, 0, 1, 1, 5'b00010, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00010, 0, 0);
    add(1, 1, 1, 0, 6, 0, 1, 5'b00000, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 5'b00001, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 5'b00001, 0, 0);
    add(1, 1, 0, 1, 0, 2, 1, 5'b00001, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 5'b00001, 0, 0);
    n_chk = 0;
    n_fail = 0;
    model_clear();
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].sel != tbl[i-1].sel) begin
        sel = tbl[i].sel;
        do_reset();
      end
      rdy = '1;
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].dir);
      emp = tbl[i].em;
      step_check();
      chk($sformatf("tbl[%0d].ready", i), rdy_s, tbl[i].xr);
      chk($sformatf("tbl[%0d].valid", i), vo_s, tbl[i].vm);
      chk($sformatf("tbl[%0d].err", i), err_s, tbl[i].xe);
      chk($sformatf("tbl[%0d].drop", i), drop_s, tbl[i].xd);
      step_adv();
    end
    // Backpressure on port 1: ready_o must never react to ready_i within a cycle
    sel = 1'b0;
    do_reset();
    rdy = '1;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      drive(1, k == 0, k == 7, 1);
      rdy[1] = 1'($urandom);
      step_check();
      r0 = rdy_s;
      rdy[1] = ~rdy[1];
      #1 chk("t3_ready_indep", rdy_s, r0);
      rdy[1] = ~rdy[1];
      #1 acc = x_ready;
      step_adv();
      if (acc) k++;
      cyc++;
    end
    chk("t3_all_accepted", k, 8);
    vin = 1'b0;
    rdy = '1;
    repeat (4) begin
      step_check();
      step_adv();
    end
    chk("t3_rx_count", rx[1], 8);
    // Reset with port 2 holding two beats
    do_reset();
    rdy = 5'b11011;
    drive(1, 1, 0, 2);
    step_check();
    step_adv();
    drive(1, 0, 0, 0);
    step_check();
    step_adv();
    drive(1, 0, 0, 0);
    step_check();
    chk("t6_ready_full", rdy_s, 1'b0);
    step_adv();
    srst = 1'b1;
    vin = 1'b0;
    step_check();
    step_adv();
    srst = 1'b0;
    step_check();
    chk("t6_valid_after_reset", vo_s, '0);
    chk("t6_ready_after_reset", rdy_s, 1'b1);
    step_adv();
    rdy = '1;
    drive(1, 1, 0, 2);
    step_check();
    step_adv();
    drive(1, 0, 0, 0);
    step_check();
    step_adv();
    drive(1, 0, 1, 0);
    step_check();
    step_adv();
    vin = 1'b0;
    repeat (3) begin
      step_check();
      step_adv();
    end
    chk("t6_rx_count", rx[2], 3);
    // Random traffic on both drop modes
    for (int m = 0; m < 2; m++) begin
      sel = m[0];
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        rdy = N'($urandom);
        drive(($urandom % 10) < 7, ($urandom % 4) == 0, ($urandom % 3) == 0, int'($urandom % 8));
        srst = ($urandom % 300) == 0;
        step_check();
        step_adv();
      end
      srst = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
